// File: rtl/inst_fetch.sv
// Instruction fetch stage: word PC into the ROM array, one registered instruction
// per cycle to decode, redirect from execute, stop on the sentinel word or on an out-of-range PC.
module inst_fetch #(
    parameter int unsigned MEM_DEPTH = 200,
    parameter logic [31:0] HALT_WORD = 32'hffff_ffff
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MEM_DEPTH-1:0][31:0] mem_inst,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       stall,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    output logic                       halted,
    output logic                       fault
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        inst_valid_q;
    logic        halted_q;
    logic        fault_q;

    logic        pc_in_range_c;
    logic [31:0] fetch_word_c;

    // ROM read at the current PC; only meaningful while the PC is in range
    always_comb begin
        pc_in_range_c = (pc_q < DEPTH);
        fetch_word_c  = '0;
        if (pc_in_range_c) begin
            fetch_word_c = mem_inst[pc_q[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else if (redirect_valid) begin
            state_q      <= RUN;
            pc_q         <= redirect_pc;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    // An empty slot is refilled even while decode stalls
                    if (!(inst_valid_q && stall)) begin
                        if (!pc_in_range_c) begin
                            inst_valid_q <= 1'b0;
                            state_q      <= FAULT;
                            fault_q      <= 1'b1;
                        end else if (fetch_word_c == HALT_WORD) begin
                            inst_valid_q <= 1'b0;
                            state_q      <= HALT;
                            halted_q     <= 1'b1;
                        end else begin
                            inst_q       <= fetch_word_c;
                            inst_pc_q    <= pc_q;
                            inst_valid_q <= 1'b1;
                            pc_q         <= pc_q + 32'd1;
                        end
                    end
                end
                HALT, FAULT: begin
                    inst_valid_q <= 1'b0;
                end
                default: begin
                    state_q      <= FAULT;
                    inst_valid_q <= 1'b0;
                    fault_q      <= 1'b1;
                    halted_q     <= 1'b0;
                end
            endcase
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign halted     = halted_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch using a small fib program image.
module tb_inst_fetch;

    localparam int unsigned DEPTH = 200;

    logic                   clk;
    logic                   rst;
    logic [DEPTH-1:0][31:0] mem;
    logic                   redirect_valid;
    logic [31:0]            redirect_pc;
    logic                   stall;
    logic                   inst_valid;
    logic [31:0]            inst;
    logic [31:0]            inst_pc;
    logic                   halted;
    logic                   fault;

    int n_cmp;
    int n_err;

    inst_fetch #(.MEM_DEPTH(DEPTH), .HALT_WORD(32'hffff_ffff)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_inst      (mem),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .halted        (halted),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares {inst_valid, inst_pc, inst, halted, fault} as one tuple
    task automatic chk(input string name, input logic v, input logic [31:0] pc,
                       input logic [31:0] w, input logic h, input logic f);
        logic [66:0] act;
        logic [66:0] exp;
        act = {inst_valid, inst_pc, inst, halted, fault};
        exp = {v, pc, w, h, f};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got v=%0b pc=%0d inst=%h h=%0b f=%0b, want v=%0b pc=%0d inst=%h h=%0b f=%0b",
                     name, inst_valid, inst_pc, inst, halted, fault, v, pc, w, h, f);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #12;
        chk("reset_values", 1'b0, 32'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        step(); chk("stream_pc0", 1'b1, 32'd0, 32'h20010014, 1'b0, 1'b0);
        step(); chk("stream_pc1", 1'b1, 32'd1, 32'hafdf0001, 1'b0, 1'b0);
        step(); chk("stream_pc2", 1'b1, 32'd2, 32'h23de0002, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall_hold", 1'b1, 32'd2, 32'h23de0002, 1'b0, 1'b0);
        end
        stall = 1'b0;
        step(); chk("stall_release", 1'b1, 32'd3, 32'h0c00000d, 1'b0, 1'b0);
    endtask

    task automatic test_redirect_stalled();
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd13;
        step(); chk("redir_squash", 1'b0, 32'd3, 32'h0c00000d, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step(); chk("redir_bubble_fill", 1'b1, 32'd13, 32'h201a0000, 1'b0, 1'b0);
        step(); chk("redir_then_hold", 1'b1, 32'd13, 32'h201a0000, 1'b0, 1'b0);
        stall = 1'b0;
        step(); chk("redir_next", 1'b1, 32'd14, mem[14], 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        redirect_valid = 1'b1;
        redirect_pc = 32'd42;
        step(); chk("halt_redir", 1'b0, 32'd14, mem[14], 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step(); chk("halt_pc42", 1'b1, 32'd42, 32'h03e00008, 1'b0, 1'b0);
        step(); chk("halt_enter", 1'b0, 32'd42, 32'h03e00008, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            step(); chk("halt_held", 1'b0, 32'd42, 32'h03e00008, 1'b1, 1'b0);
        end
        stall = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        step(); chk("halt_exit", 1'b0, 32'd42, 32'h03e00008, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step(); chk("halt_exit_pc0", 1'b1, 32'd0, 32'h20010014, 1'b0, 1'b0);
    endtask

    task automatic test_fault_and_async_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'd200;
        step();
        redirect_valid = 1'b0;
        step(); chk("fault_enter", 1'b0, 32'd0, 32'h20010014, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(); chk("fault_held", 1'b0, 32'd0, 32'h20010014, 1'b0, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 1'b0, 32'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(); chk("post_reset_pc0", 1'b1, 32'd0, 32'h20010014, 1'b0, 1'b0);
    endtask

    task automatic test_redirect_beats_halt();
        redirect_valid = 1'b1;
        redirect_pc = 32'd42;
        step();
        redirect_valid = 1'b0;
        step(); chk("race_pc42", 1'b1, 32'd42, 32'h03e00008, 1'b0, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 32'd5;
        step(); chk("race_no_halt", 1'b0, 32'd42, 32'h03e00008, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step(); chk("race_target", 1'b1, 32'd5, mem[5], 1'b0, 1'b0);
    endtask

    task automatic test_range_edges();
        redirect_valid = 1'b1;
        redirect_pc = 32'd199;
        step();
        redirect_valid = 1'b0;
        step(); chk("last_word", 1'b1, 32'd199, mem[199], 1'b0, 1'b0);
        step(); chk("past_end", 1'b0, 32'd199, mem[199], 1'b0, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 32'hffff_ffff;
        step();
        redirect_valid = 1'b0;
        step(); chk("max_pc", 1'b0, 32'd199, mem[199], 1'b0, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0]  = 32'h20010014;
        mem[1]  = 32'hafdf0001;
        mem[2]  = 32'h23de0002;
        mem[3]  = 32'h0c00000d;
        mem[13] = 32'h201a0000;
        mem[42] = 32'h03e00008;
        mem[43] = 32'hffffffff;

        test_reset();
        test_stream();
        test_stall();
        test_redirect_stalled();
        test_halt();
        test_fault_and_async_reset();
        test_redirect_beats_halt();
        test_range_edges();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
